// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
//   arb_state_e : arbiter FSM state (IDLE = no owner, OWN = grant held)
//   pick_t      : result of a round-robin search (found flag + index)
//   rr_pick     : reference round-robin search over ARB_WIDTH requesters,
//                 first set bit of vld starting at ptr and wrapping
package arb_pkg;

  localparam int ARB_WIDTH = 4;
  localparam int IDX_W     = $clog2(ARB_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [ARB_WIDTH-1:0] vld,
                                    input logic [IDX_W-1:0]     ptr);
    pick_t r;
    int    j;
    r = '0;
    // Walk downward so the closest requester to ptr is the last writer.
    for (int k = ARB_WIDTH - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % ARB_WIDTH;
      if (vld[j]) begin
        r.found = 1'b1;
        r.idx   = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker.
//   vld_i   : request vector
//   ptr_i   : search start index
//   found_o : at least one request is set
//   idx_o   : first set request at or after ptr_i, wrapping
// Rotates the request vector so ptr_i sits at bit 0, finds the lowest set
// bit, then adds ptr_i back (mod WIDTH) to recover the absolute index.
module arb_rr_pick #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vld_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] WIDTH_L = (IDX_W + 1)'(WIDTH);

  logic [WIDTH-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    rot = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int j;
      j = k + int'(ptr_i);
      if (j >= WIDTH) j = j - WIDTH;
      rot[k] = vld_i[j];
    end

    off = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (rot[k]) off = k[IDX_W-1:0];
    end

    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= WIDTH_L) sum = sum - WIDTH_L;
  end

  assign found_o = |rot;
  assign idx_o   = sum[IDX_W-1:0];

endmodule

// File: rtl/arb_wrr_lock.sv
// Weighted round-robin arbiter with grant lock.
//   clk, rst  : clock, synchronous active-high reset
//   v_vld     : per-requester request/valid
//   v_last    : per-requester last-beat marker (owner, accepted beats only)
//   v_weight  : per-requester weight, requester i at [i*WGT_W +: WGT_W]
//   rdy       : downstream accepts a beat this cycle
//   v_grant   : registered one-hot grant, zero when idle
//   grant_idx : registered index of the current owner
//   busy      : registered, high while a grant is held
// An owner keeps the grant for up to weight accepted beats, or until it
// signals last or withdraws. Handover picks from owner+1 in the same cycle,
// so consecutive owners have no dead cycle between them.
module arb_wrr_lock
  import arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WGT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         v_vld,
  input  logic [WIDTH-1:0]         v_last,
  input  logic [WIDTH*WGT_W-1:0]   v_weight,
  input  logic                     rdy,
  output logic [WIDTH-1:0]         v_grant,
  output logic [$clog2(WIDTH)-1:0] grant_idx,
  output logic                     busy
);

  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [WIDTH-1:0] grant_q, grant_d;

  logic [IW-1:0]    rel_ptr, pick_ptr, pick_idx;
  logic             pick_found;
  logic [WGT_W-1:0] pick_wgt;
  logic             own_vld, beat, release_c;

  assign own_vld   = v_vld[owner_q];
  assign beat      = own_vld & rdy;
  assign release_c = (state_q == OWN) &
                     ((beat & ((credit_q == WGT_W'(1)) | v_last[owner_q])) | ~own_vld);

  // On release the search must start after the old owner, so it only wins
  // when nobody else is asking.
  assign rel_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
  assign pick_ptr = (state_q == OWN) ? rel_ptr : ptr_q;

  arb_rr_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IW)
  ) u_pick (
    .vld_i   (v_vld),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_wgt = v_weight[pick_idx*WGT_W +: WGT_W];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;

    if ((state_q == IDLE) || release_c) begin
      if (state_q == OWN) ptr_d = rel_ptr;
      if (pick_found) begin
        state_d  = OWN;
        owner_d  = pick_idx;
        grant_d  = '0;
        grant_d[pick_idx] = 1'b1;
        // A zero weight still buys one beat.
        credit_d = (pick_wgt == '0) ? WGT_W'(1) : pick_wgt;
      end else begin
        state_d  = IDLE;
        grant_d  = '0;
        credit_d = '0;
      end
    end else if (beat) begin
      credit_d = credit_q - WGT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
    end
  end

  assign v_grant   = grant_q;
  assign grant_idx = owner_q;
  assign busy      = (state_q == OWN);

endmodule

// File: doc/arb_wrr_lock.md
# arb_wrr_lock

Weighted round-robin arbiter with grant lock for sharing one downstream resource between WIDTH requesters. A granted requester owns the resource for up to its configured weight in accepted beats, or until it marks a last beat or withdraws. Ownership then rotates to the next requester. It sits in front of a shared port and drives its select/enable. It is the burst-aware successor to the plain round-robin arbiter.

## Interface
- WIDTH, 4, number of requesters (≥2)
- WGT_W, 4, weight/credit counter width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- v_vld  in  WIDTH  per-requester request/valid
- v_last  in  WIDTH  per-requester last-beat marker, sampled only on an accepted beat of the owner
- v_weight  in  WIDTH*WGT_W  per-requester weight, requester i at [i*WGT_W +: WGT_W]; quasi-static, sampled at grant time
- rdy  in  1  resource accepts a beat this cycle
- v_grant  out  WIDTH  registered one-hot grant, all-zero when idle
- grant_idx  out  $clog2(WIDTH)  registered index of current owner, valid when busy
- busy  out  1  registered; high while a grant is held

## Operation
- States: IDLE, OWN. Registers: state, owner, credit[WGT_W], ptr (next search start).
- Pick function: the first set bit of v_vld, searching from ptr upward with wrap. Returns found plus index.
- IDLE: if any v_vld, grant the pick. v_grant = onehot(idx), grant_idx = idx, credit = weight[idx] (weight 0 loads as 1), go to OWN. Otherwise stay.
- OWN: beat = v_vld[owner] & rdy. On a beat, credit decrements.
- Release condition in OWN: (beat & (credit==1 | v_last[owner])) | !v_vld[owner].
- On release: ptr = owner+1 mod WIDTH. Same cycle, pick over current v_vld from the new ptr.
  - If found: regrant directly and stay in OWN with no idle cycle.
  - If not found: go to IDLE and clear v_grant.
- The old owner can win the regrant only if no other requester is valid. Owner has lowest priority at release.
- While in OWN with no release, v_grant, grant_idx and credit change only as above. Other v_vld edges are ignored.
- v_last is ignored when there is no beat. v_last with credit > 1 still releases.
- Weight changes take effect at the next grant only.

## Timing
- Reset values: state IDLE, v_grant 0, grant_idx 0, busy 0, ptr 0, credit 0. Reset overrides everything. Reset mid-grant drops the grant on the next edge.
- Request-to-grant latency is 1 cycle: v_vld seen at edge N gives v_grant at N+1.
- The beat that releases is the owner's last granted beat. The new owner's v_grant is visible the next cycle.
- Back-to-back handover has zero dead cycles.
- Weight W with rdy continuously high: exactly W beats per tenure, unless v_last comes earlier.
- Maximum credit is 2^WGT_W−1. The decrement never wraps, because release fires at credit==1.
- Withdrawal (owner v_vld low) releases in that cycle with no beat counted.
- Grant-after-release priority uses the updated ptr, never the stale one.

## Structure
- Package arb_pkg:
  - state enum arb_state_e {IDLE, OWN}
  - function rr_pick(vld, ptr) returning found + index, shared with arb_rr
  - localparam IDX_W = $clog2(WIDTH)
- Sub-module arb_rr_pick: combinational rotate, priority-encode, un-rotate. Instantiated once in arb_wrr_lock.
- Top holds the state register, owner/credit/ptr registers and the release logic.

## Test plan
- Reset, then v_vld=4'b1111, all weights 2, rdy=1 → grants 0,0,1,1,2,2,3,3,0…; first grant one cycle after rst falls; no idle cycles between owners.
- Weights {1,3,0,2} for idx {0,1,2,3}, all valid, rdy=1 → tenures of 1,3,1,2 beats; weight 0 behaves as 1.
- Owner 1 with weight 8, v_last[1] on 3rd beat, v_vld=4'b0110 → release after beat 3; requester 2 granted next cycle; ptr=2.
- Owner 2 with rdy toggling 1,0,0,1,1 and weight 3 → credit holds on rdy=0 cycles; release after the 3rd accepted beat; v_grant stable throughout.
- Only requester 3 valid, weight 2, continuous → regranted to 3 back-to-back with fresh credit; owner drops v_vld mid-tenure → busy=0, v_grant=0 next cycle.
- rst asserted for one cycle during an OWN tenure → next cycle all outputs at reset values; with v_vld=4'b1000 afterwards, grant to 3 one cycle after rst low, search starting from ptr=0.
